// File: rtl/carpma_paket.sv
// Shared types and helpers for the multiply controller and its product cache.
package carpma_paket;

   typedef enum logic [1:0] {
      ISLEM_MUL    = 2'b00,
      ISLEM_MULH   = 2'b01,
      ISLEM_MULHSU = 2'b10,
      ISLEM_MULHU  = 2'b11
   } islem_t;

   typedef enum logic [1:0] {
      BOS     = 2'd0,
      HESAPLA = 2'd1,
      BOSALT  = 2'd2,
      SUNUM   = 2'd3
   } durum_t;

   // MOD_SIGNED is the all-zero encoding so both mode pins idle low
   typedef enum logic [1:0] {
      MOD_SIGNED   = 2'd0,
      MOD_UNSIGNED = 2'd1,
      MOD_MULHSU   = 2'd2
   } mod_t;

   localparam int GECIKME_UNSIGNED = 4;
   localparam int GECIKME_SIGNED   = 5;

   // MUL only needs the low half, which is identical in every mode
   function automatic mod_t islem_modu(input islem_t islem);
      case (islem)
         ISLEM_MUL, ISLEM_MULHU: islem_modu = MOD_UNSIGNED;
         ISLEM_MULHSU:           islem_modu = MOD_MULHSU;
         default:                islem_modu = MOD_SIGNED;
      endcase
   endfunction

   function automatic logic [31:0] sonuc_yarisi(input logic [63:0] carpim, input islem_t islem);
      sonuc_yarisi = (islem == ISLEM_MUL) ? carpim[31:0] : carpim[63:32];
   endfunction

endpackage

// File: rtl/carpma_onbellek.sv
// Single-entry product cache: remembers the last completed multiply and its mode.
module carpma_onbellek
   import carpma_paket::*;
#(
   parameter bit AKTIF = 1'b1
)
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] ara_rs1,
   input  logic [31:0] ara_rs2,
   input  islem_t      ara_islem,
   output logic        isabet,
   output logic [63:0] isabet_carpim,
   input  logic        yaz,
   input  logic [31:0] yaz_rs1,
   input  logic [31:0] yaz_rs2,
   input  mod_t        yaz_mod,
   input  logic [63:0] yaz_carpim
);

   logic        gecerli;
   logic [31:0] rs1_k;
   logic [31:0] rs2_k;
   mod_t        mod_k;
   logic [63:0] carpim_k;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         gecerli  <= 1'b0;
         rs1_k    <= '0;
         rs2_k    <= '0;
         mod_k    <= MOD_SIGNED;
         carpim_k <= '0;
      end else if (yaz) begin
         gecerli  <= 1'b1;
         rs1_k    <= yaz_rs1;
         rs2_k    <= yaz_rs2;
         mod_k    <= yaz_mod;
         carpim_k <= yaz_carpim;
      end
   end

   // A MUL can reuse any cached product; the high-half ops need the same signedness
   always_comb begin
      isabet = 1'b0;
      if (AKTIF && gecerli && (ara_rs1 == rs1_k) && (ara_rs2 == rs2_k)) begin
         isabet = (ara_islem == ISLEM_MUL) || (islem_modu(ara_islem) == mod_k);
      end
   end

   assign isabet_carpim = carpim_k;

endmodule

// File: rtl/carpma_denetleyici.sv
// Controller between execute and the shared pipelined 32x32 multiplier.
module carpma_denetleyici
   import carpma_paket::*;
#(
   parameter bit ONBELLEK_AKTIF = 1'b1
)
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        istek_gecerli_i,
   output logic        istek_hazir_o,
   input  logic [1:0]  islem_i,
   input  logic [31:0] rs1_i,
   input  logic [31:0] rs2_i,
   input  logic        iptal_i,
   output logic [31:0] sonuc_o,
   output logic        sonuc_gecerli_o,
   input  logic        sonuc_hazir_i,
   output logic        blok_aktif_o,
   output logic        carpim_unsigned_o,
   output logic        carpim_mulhsu_o,
   output logic [31:0] sayi1_o,
   output logic [31:0] sayi2_o,
   input  logic [63:0] carpim_sonuc_i,
   input  logic        carpim_hazir_i
);

   durum_t      durum, durum_sonraki;
   logic        kabul;
   logic        onbellek_yaz;
   logic        isabet;
   logic [63:0] isabet_carpim;
   islem_t      islem_q;
   mod_t        mod_q;
   logic [31:0] sonuc_q;

   carpma_onbellek #(
      .AKTIF(ONBELLEK_AKTIF)
   ) u_onbellek (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .ara_rs1      (rs1_i),
      .ara_rs2      (rs2_i),
      .ara_islem    (islem_t'(islem_i)),
      .isabet       (isabet),
      .isabet_carpim(isabet_carpim),
      .yaz          (onbellek_yaz),
      .yaz_rs1      (sayi1_o),
      .yaz_rs2      (sayi2_o),
      .yaz_mod      (mod_q),
      .yaz_carpim   (carpim_sonuc_i)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         durum <= BOS;
      end else begin
         durum <= durum_sonraki;
      end
   end

   // Once started, the multiplier runs to carpim_hazir_i even if the op was flushed
   always_comb begin
      durum_sonraki   = durum;
      istek_hazir_o   = 1'b0;
      blok_aktif_o    = 1'b0;
      sonuc_gecerli_o = 1'b0;
      kabul           = 1'b0;
      onbellek_yaz    = 1'b0;
      case (durum)
         BOS: begin
            istek_hazir_o = !iptal_i;
            kabul         = istek_gecerli_i && !iptal_i;
            if (kabul) begin
               durum_sonraki = isabet ? SUNUM : HESAPLA;
            end
         end
         HESAPLA: begin
            blok_aktif_o = 1'b1;
            if (carpim_hazir_i) begin
               onbellek_yaz  = 1'b1;
               durum_sonraki = iptal_i ? BOS : SUNUM;
            end else if (iptal_i) begin
               durum_sonraki = BOSALT;
            end
         end
         BOSALT: begin
            blok_aktif_o = 1'b1;
            if (carpim_hazir_i) begin
               onbellek_yaz  = 1'b1;
               durum_sonraki = BOS;
            end
         end
         SUNUM: begin
            sonuc_gecerli_o = 1'b1;
            if (iptal_i || sonuc_hazir_i) begin
               durum_sonraki = BOS;
            end
         end
         default: durum_sonraki = BOS;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         sayi1_o <= '0;
         sayi2_o <= '0;
         islem_q <= ISLEM_MUL;
         mod_q   <= MOD_SIGNED;
         sonuc_q <= '0;
      end else if (kabul) begin
         sayi1_o <= rs1_i;
         sayi2_o <= rs2_i;
         islem_q <= islem_t'(islem_i);
         mod_q   <= islem_modu(islem_t'(islem_i));
         if (isabet) begin
            sonuc_q <= sonuc_yarisi(isabet_carpim, islem_t'(islem_i));
         end
      end else if ((durum == HESAPLA) && carpim_hazir_i) begin
         sonuc_q <= sonuc_yarisi(carpim_sonuc_i, islem_q);
      end
   end

   assign carpim_unsigned_o = (mod_q == MOD_UNSIGNED);
   assign carpim_mulhsu_o   = (mod_q == MOD_MULHSU);
   assign sonuc_o           = sonuc_q;

endmodule

// File: tb/tb_carpma_denetleyici.sv
// Bench for carpma_denetleyici: multiplier stand-in, directed scenarios and a randomized run.
module tb_carpma_denetleyici;

   localparam bit ONBELLEK = 1'b1;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        istek_gecerli_i = 1'b0;
   logic        istek_hazir_o;
   logic [1:0]  islem_i = 2'b00;
   logic [31:0] rs1_i = '0;
   logic [31:0] rs2_i = '0;
   logic        iptal_i = 1'b0;
   logic [31:0] sonuc_o;
   logic        sonuc_gecerli_o;
   logic        sonuc_hazir_i = 1'b0;
   logic        blok_aktif_o;
   logic        carpim_unsigned_o;
   logic        carpim_mulhsu_o;
   logic [31:0] sayi1_o;
   logic [31:0] sayi2_o;
   logic [63:0] carpim_sonuc_i;
   logic        carpim_hazir_i;

   int toplam = 0;
   int gecen  = 0;

   always #5 clk_i = ~clk_i;

   carpma_denetleyici #(
      .ONBELLEK_AKTIF(ONBELLEK)
   ) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .istek_gecerli_i  (istek_gecerli_i),
      .istek_hazir_o    (istek_hazir_o),
      .islem_i          (islem_i),
      .rs1_i            (rs1_i),
      .rs2_i            (rs2_i),
      .iptal_i          (iptal_i),
      .sonuc_o          (sonuc_o),
      .sonuc_gecerli_o  (sonuc_gecerli_o),
      .sonuc_hazir_i    (sonuc_hazir_i),
      .blok_aktif_o     (blok_aktif_o),
      .carpim_unsigned_o(carpim_unsigned_o),
      .carpim_mulhsu_o  (carpim_mulhsu_o),
      .sayi1_o          (sayi1_o),
      .sayi2_o          (sayi2_o),
      .carpim_sonuc_i   (carpim_sonuc_i),
      .carpim_hazir_i   (carpim_hazir_i)
   );

   // Full 64-bit product of the two operands under the given signedness
   function automatic logic [63:0] carp(input logic [31:0] a, input logic [31:0] b,
                                        input logic uns, input logic hsu);
      logic [63:0] x;
      logic [63:0] y;
      x = uns ? {32'b0, a} : {{32{a[31]}}, a};
      y = (uns || hsu) ? {32'b0, b} : {{32{b[31]}}, b};
      return x * y;
   endfunction

   // Multiplier stand-in: done in the 4th (unsigned) or 5th consecutive active cycle
   logic [2:0] carpan_sayac;
   assign carpim_hazir_i = blok_aktif_o && (carpan_sayac == (carpim_unsigned_o ? 3'd3 : 3'd4));
   assign carpim_sonuc_i = carp(sayi1_o, sayi2_o, carpim_unsigned_o, carpim_mulhsu_o);

   always @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) carpan_sayac <= '0;
      else if (blok_aktif_o) carpan_sayac <= carpim_hazir_i ? 3'd0 : carpan_sayac + 3'd1;
   end

   task automatic checkOutput(input string ad, input logic [63:0] gercek, input logic [63:0] beklenen);
      toplam++;
      if (gercek === beklenen) gecen++;
      else $display("[TB] FAIL %s: actual=%0h required=%0h", ad, gercek, beklenen);
   endtask

   task automatic applyStimulus(input logic gecerli, input logic [1:0] islem, input logic [31:0] a,
                                input logic [31:0] b, input logic iptal, input logic hazir);
      @(posedge clk_i);
      #1;
      istek_gecerli_i = gecerli;
      islem_i         = islem;
      rs1_i           = a;
      rs2_i           = b;
      iptal_i         = iptal;
      sonuc_hazir_i   = hazir;
   endtask

   // Reference model: op-level view of the controller (busy countdown, pending result, cache)
   function automatic int mod_of(input logic [1:0] op);
      if (op == 2'd0 || op == 2'd3) return 0;
      if (op == 2'd2) return 1;
      return 2;
   endfunction

   function automatic logic [31:0] yari(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
      logic [63:0] p;
      p = carp(a, b, mod_of(op) == 0, mod_of(op) == 1);
      return (op == 2'd0) ? p[31:0] : p[63:32];
   endfunction

   int          m_kalan = 0;
   bit          m_atilacak = 0;
   bit          m_sonuc_gecerli = 0;
   logic [31:0] m_sonuc = '0;
   logic [31:0] m_a = '0;
   logic [31:0] m_b = '0;
   logic [1:0]  m_op = '0;
   bit          mc_gecerli = 0;
   logic [31:0] mc_a = '0;
   logic [31:0] mc_b = '0;
   int          mc_mod = 0;

   always @(negedge clk_i) begin
      if (!rst_i) begin
         m_kalan = 0;
         m_sonuc_gecerli = 0;
         mc_gecerli = 0;
         checkOutput("rst_blok", blok_aktif_o, 0);
         checkOutput("rst_gecerli", sonuc_gecerli_o, 0);
         checkOutput("rst_sonuc", sonuc_o, 0);
         checkOutput("rst_istek_hazir", istek_hazir_o, !iptal_i);
      end else begin
         checkOutput("istek_hazir", istek_hazir_o, (m_kalan == 0 && !m_sonuc_gecerli && !iptal_i));
         checkOutput("blok_aktif", blok_aktif_o, m_kalan > 0);
         checkOutput("sonuc_gecerli", sonuc_gecerli_o, m_sonuc_gecerli);
         if (m_sonuc_gecerli) checkOutput("sonuc", sonuc_o, m_sonuc);
         if (m_kalan > 0) begin
            checkOutput("sayi1", sayi1_o, m_a);
            checkOutput("sayi2", sayi2_o, m_b);
            checkOutput("mod_unsigned", carpim_unsigned_o, mod_of(m_op) == 0);
            checkOutput("mod_mulhsu", carpim_mulhsu_o, mod_of(m_op) == 1);
         end
         if (m_kalan > 0) begin
            if (iptal_i) m_atilacak = 1;
            if (m_kalan == 1) begin
               mc_gecerli = 1;
               mc_a = m_a;
               mc_b = m_b;
               mc_mod = mod_of(m_op);
               if (!m_atilacak) begin
                  m_sonuc_gecerli = 1;
                  m_sonuc = yari(m_a, m_b, m_op);
               end
            end
            m_kalan--;
         end else if (m_sonuc_gecerli) begin
            if (iptal_i || sonuc_hazir_i) m_sonuc_gecerli = 0;
         end else if (istek_gecerli_i && !iptal_i) begin
            m_a = rs1_i;
            m_b = rs2_i;
            m_op = islem_i;
            if (ONBELLEK && mc_gecerli && m_a == mc_a && m_b == mc_b &&
                (m_op == 2'd0 || mod_of(m_op) == mc_mod)) begin
               m_sonuc_gecerli = 1;
               m_sonuc = yari(m_a, m_b, m_op);
            end else begin
               m_kalan = (mod_of(m_op) == 0) ? 4 : 5;
               m_atilacak = 0;
            end
         end
      end
   end

   // One request through to acceptance of its result; reports active cycles and latency
   task automatic istek_gonder(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               output int blok, output int gec, output logic [31:0] son,
                               output logic uns, output logic hsu);
      blok = 0; gec = 0; son = '0; uns = 1'b0; hsu = 1'b0;
      applyStimulus(1'b1, op, a, b, 1'b0, 1'b0);
      #1;
      checkOutput("kabul_hazir", istek_hazir_o, 1);
      for (int k = 1; k <= 20; k++) begin
         applyStimulus(1'b0, 2'd0, '0, '0, 1'b0, 1'b0);
         #1;
         if (blok_aktif_o) begin
            blok++;
            uns = uns | carpim_unsigned_o;
            hsu = hsu | carpim_mulhsu_o;
         end
         if (sonuc_gecerli_o) begin
            gec = k;
            son = sonuc_o;
            break;
         end
      end
      if (gec == 0) checkOutput("zaman_asimi", 0, 1);
      applyStimulus(1'b0, 2'd0, '0, '0, 1'b0, 1'b1);
      applyStimulus(1'b0, 2'd0, '0, '0, 1'b0, 1'b0);
   endtask

   function automatic logic [31:0] rastgele_sayi();
      case ($urandom_range(0, 4))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h0000_0003;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int blok, gec, hazir_k, carpim_k, blok_say;
      logic [31:0] son;
      logic uns, hsu;
      bit gecerli_gordu;

      repeat (3) applyStimulus(1'b0, 2'd0, '0, '0, 1'b0, 1'b0);
      #1;
      checkOutput("ilk_mod_unsigned", carpim_unsigned_o, 0);
      checkOutput("ilk_mod_mulhsu", carpim_mulhsu_o, 0);
      checkOutput("ilk_sayi1", sayi1_o, 0);
      checkOutput("ilk_istek_hazir", istek_hazir_o, 1);
      applyStimulus(1'b0, 2'd0, '0, '0, 1'b0, 1'b0);
      rst_i = 1'b1;
      applyStimulus(1'b0, 2'd0, '0, '0, 1'b0, 1'b0);

      istek_gonder(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, blok, gec, son, uns, hsu);
      checkOutput("mulhu_blok", blok, 4);
      checkOutput("mulhu_gecikme", gec, 5);
      checkOutput("mulhu_sonuc", son, 32'hFFFF_FFFE);
      checkOutput("mulhu_mod", uns, 1);

      istek_gonder(2'd1, 32'hFFFF_FFFE, 32'h0000_0003, blok, gec, son, uns, hsu);
      checkOutput("mulh_blok", blok, 5);
      checkOutput("mulh_gecikme", gec, 6);
      checkOutput("mulh_sonuc", son, 32'hFFFF_FFFF);
      istek_gonder(2'd0, 32'hFFFF_FFFE, 32'h0000_0003, blok, gec, son, uns, hsu);
      checkOutput("mul_isabet_blok", blok, 0);
      checkOutput("mul_isabet_gecikme", gec, 1);
      checkOutput("mul_isabet_sonuc", son, 32'hFFFF_FFFA);

      istek_gonder(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, blok, gec, son, uns, hsu);
      checkOutput("mulhsu_blok", blok, 5);
      checkOutput("mulhsu_mod", hsu, 1);
      checkOutput("mulhsu_sonuc", son, 32'hFFFF_FFFF);

      // Flush in the second active cycle of a MULH
      applyStimulus(1'b1, 2'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
      blok_say = 0; hazir_k = 0; carpim_k = 0; gecerli_gordu = 0;
      for (int k = 1; k <= 15; k++) begin
         applyStimulus(1'b0, 2'd0, '0, '0, (k == 2), 1'b0);
         #1;
         if (sonuc_gecerli_o) gecerli_gordu = 1;
         if (carpim_hazir_i) carpim_k = k;
         if (blok_aktif_o) blok_say++;
         else begin
            hazir_k = k;
            checkOutput("iptal_sonra_hazir", istek_hazir_o, 1);
            break;
         end
      end
      checkOutput("iptal_blok", blok_say, 5);
      checkOutput("iptal_carpim_hazir", carpim_k, 5);
      checkOutput("iptal_hazir_cevrim", hazir_k, 6);
      checkOutput("iptal_sonuc_yok", gecerli_gordu, 0);
      istek_gonder(2'd1, 32'h8000_0000, 32'h8000_0000, blok, gec, son, uns, hsu);
      checkOutput("iptal_dolum_gecikme", gec, 1);
      checkOutput("iptal_dolum_sonuc", son, 32'h4000_0000);

      // Downstream stall, then flush together with accept
      applyStimulus(1'b1, 2'd0, 32'h1234_5678, 32'h0000_0010, 1'b0, 1'b0);
      gec = 0;
      for (int k = 1; k <= 20; k++) begin
         applyStimulus(1'b0, 2'd0, '0, '0, 1'b0, 1'b0);
         #1;
         if (sonuc_gecerli_o) begin
            gec = k;
            break;
         end
      end
      checkOutput("bekle_gecikme", gec, 5);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 2'd0, '0, '0, 1'b0, 1'b0);
         #1;
         checkOutput("bekle_sonuc", sonuc_o, 32'h2345_6780);
         checkOutput("bekle_istek_hazir", istek_hazir_o, 0);
      end
      applyStimulus(1'b0, 2'd0, '0, '0, 1'b1, 1'b1);
      applyStimulus(1'b0, 2'd0, '0, '0, 1'b0, 1'b0);
      #1;
      checkOutput("iptal_dusur", sonuc_gecerli_o, 0);
      checkOutput("iptal_dusur_hazir", istek_hazir_o, 1);

      // Asynchronous reset in the middle of a computation
      istek_gonder(2'd0, 32'd5, 32'd6, blok, gec, son, uns, hsu);
      checkOutput("mul56_sonuc", son, 30);
      istek_gonder(2'd0, 32'd5, 32'd6, blok, gec, son, uns, hsu);
      checkOutput("mul56_isabet", gec, 1);
      applyStimulus(1'b1, 2'd1, 32'h0000_1000, 32'h0000_1000, 1'b0, 1'b0);
      applyStimulus(1'b0, 2'd0, '0, '0, 1'b0, 1'b0);
      applyStimulus(1'b0, 2'd0, '0, '0, 1'b0, 1'b0);
      #1;
      checkOutput("rst_oncesi_blok", blok_aktif_o, 1);
      rst_i = 1'b0;
      #1;
      checkOutput("async_blok", blok_aktif_o, 0);
      checkOutput("async_gecerli", sonuc_gecerli_o, 0);
      checkOutput("async_mod", {carpim_unsigned_o, carpim_mulhsu_o}, 0);
      checkOutput("async_sayi", {sayi1_o, sayi2_o}, 0);
      checkOutput("async_sonuc", sonuc_o, 0);
      checkOutput("async_istek_hazir", istek_hazir_o, 1);
      applyStimulus(1'b0, 2'd0, '0, '0, 1'b0, 1'b0);
      rst_i = 1'b1;
      istek_gonder(2'd0, 32'd5, 32'd6, blok, gec, son, uns, hsu);
      checkOutput("rst_sonra_iska_blok", blok, 4);
      checkOutput("rst_sonra_iska_gecikme", gec, 5);
      checkOutput("rst_sonra_sonuc", son, 30);

      // Randomized traffic with flushes, stalls and rare resets
      for (int i = 0; i < 3000; i++) begin
         applyStimulus($urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)), rastgele_sayi(),
                       rastgele_sayi(), $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1);
         rst_i = ($urandom_range(0, 399) != 0);
      end
      applyStimulus(1'b0, 2'd0, '0, '0, 1'b0, 1'b0);
      rst_i = 1'b1;
      repeat (3) applyStimulus(1'b0, 2'd0, '0, '0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", gecen, toplam);
      $finish;
   end

endmodule

// File: doc/carpma_denetleyici.md
# carpma_denetleyici

Controller that sits between the execute stage and the shared 32x32 pipelined multiplier. It decodes RISC-V M-extension multiply ops (MUL, MULH, MULHSU, MULHU), drives the multiplier's mode and operand inputs, and selects the low or high 32-bit half of the product. It absorbs pipeline flushes without corrupting the multiplier's internal sequence, and keeps a single-entry product cache so that a MULH*/MUL pair on the same operands costs one multiply.

## Interface
- ONBELLEK_AKTIF, 1: 1 enables the single-entry product cache; 0 forces every request to miss.
- clk_i  in  1  single clock
- rst_i  in  1  asynchronous, active-low reset
- istek_gecerli_i  in  1  request valid from execute
- istek_hazir_o  out  1  controller can accept a request
- islem_i  in  2  op: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- rs1_i, rs2_i  in  32 each  operands
- iptal_i  in  1  pipeline flush
- sonuc_o  out  32  selected result half
- sonuc_gecerli_o  out  1  result valid
- sonuc_hazir_i  in  1  downstream accepts result
- blok_aktif_o  out  1  multiplier enable
- carpim_unsigned_o, carpim_mulhsu_o  out  1 each  multiplier mode (both 0 = signed)
- sayi1_o, sayi2_o  out  32 each  multiplier operands, registered
- carpim_sonuc_i  in  64  multiplier product
- carpim_hazir_i  in  1  multiplier done (combinational, one cycle)

## Operation
- Multiplier contract:
  - Operands and mode must stay stable while blok_aktif_o=1.
  - Unsigned mode: carpim_hazir_i in the 4th consecutive active cycle.
  - Signed and MULHSU modes: carpim_hazir_i in the 5th consecutive active cycle.
  - Deasserting blok_aktif_o mid-sequence freezes the multiplier, so it is never dropped before carpim_hazir_i.
- Mode map:
  - MUL and MULHU use unsigned mode, because MUL's low half is sign-independent.
  - MULHSU uses mulhsu mode: rs1 signed, rs2 unsigned.
  - MULH uses signed mode.
- States:
  - BOS: idle. istek_hazir_o = !iptal_i.
    - On accept, latch operands, op and mode.
    - Cache hit: go to SUNUM with the cached product.
    - Miss: go to HESAPLA.
  - HESAPLA: blok_aktif_o=1.
    - On carpim_hazir_i, capture the product, fill the cache and go to SUNUM.
    - iptal_i: go to BOSALT.
  - BOSALT: blok_aktif_o=1.
    - On carpim_hazir_i, fill the cache, discard the result and go to BOS.
    - Further iptal_i is ignored.
  - SUNUM: sonuc_gecerli_o=1.
    - sonuc_hazir_i: go to BOS.
    - iptal_i: go to BOS and drop the result. iptal_i wins over a simultaneous sonuc_hazir_i.
- Cache: one entry holding {valid, rs1, rs2, mode, product[63:0]}.
  - MUL hits when the operands match, in any mode.
  - MULH, MULHSU and MULHU hit only when both operands and mode match.
  - Each completed multiply overwrites the entry. Only rst_i clears valid.
- Result: sonuc_o = product[31:0] for MUL, product[63:32] otherwise. It is registered and held while sonuc_gecerli_o=1.
- iptal_i together with istek_gecerli_i in BOS: the request is not accepted.
- Reset mid-operation: the controller returns to BOS and the cache is invalidated. The multiplier shares rst_i and also restarts.

## Timing
- Request accepted at cycle T.
- MUL or MULHU miss: blok_aktif_o high T+1..T+4; sonuc_gecerli_o from T+5.
- MULH or MULHSU miss: blok_aktif_o high T+1..T+5; sonuc_gecerli_o from T+6.
- Cache hit: sonuc_gecerli_o from T+1; blok_aktif_o stays 0.
- blok_aktif_o is 0 in the cycle after carpim_hazir_i.
- If a result is accepted at cycle R, the next request can be accepted at R+1.
- Reset values:
  - State BOS.
  - blok_aktif_o, sonuc_gecerli_o, both mode outputs, sayi1_o, sayi2_o and sonuc_o all 0.
  - Cache invalid.
  - istek_hazir_o = !iptal_i.

## Structure
- Package carpma_paket holds:
  - islem encodings (MUL/MULH/MULHSU/MULHU)
  - state encoding (BOS/HESAPLA/BOSALT/SUNUM)
  - mode encoding (unsigned/mulhsu/signed)
  - latency constants 4 and 5
- One sub-module, carpma_onbellek: the single-entry cache, with a lookup port (rs1, rs2, islem → hit, product) and a fill port.

## Test plan
- MULHU 0xFFFFFFFF x 0xFFFFFFFF, miss:
  - blok_aktif_o for 4 cycles, carpim_unsigned_o=1.
  - sonuc_o=0xFFFFFFFE at T+5.
- MULH 0xFFFFFFFE x 0x00000003, then MUL on the same operands:
  - MULH gives sonuc_o=0xFFFFFFFF at T+6.
  - MUL hits and gives 0xFFFFFFFA one cycle after its accept, with no blok_aktif_o.
- MULHSU 0xFFFFFFFF x 0xFFFFFFFF → sonuc_o=0xFFFFFFFF, with carpim_mulhsu_o=1 for 5 active cycles.
- iptal_i in the 2nd HESAPLA cycle of a MULH:
  - blok_aktif_o stays high until carpim_hazir_i.
  - No sonuc_gecerli_o.
  - istek_hazir_o returns the cycle after carpim_hazir_i.
- sonuc_hazir_i held low for 3 cycles in SUNUM:
  - sonuc_o stays stable and istek_hazir_o=0.
  - iptal_i together with sonuc_hazir_i drops the result.
- rst_i low asynchronously mid-HESAPLA:
  - All outputs go to reset values immediately.
  - After reset, a MUL on the previous operands misses.
